// File: rtl/data_arb_pkg.sv
// Shared types and constants for the data_mem arbiter: FSM states, port IDs,
// data_mem size/sign codes and the latched request record.
package data_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam logic [3:0] SM_WORD   = 4'b0100;
  localparam logic [3:0] SM_HALF   = 4'b0010;
  localparam logic [3:0] SM_BYTE   = 4'b0000;
  localparam logic [3:0] SM_SIGNED = 4'b1000;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sign_mask;
  } arb_req_t;

endpackage

// File: rtl/data_arb_pick.sv
// Winner selection between the two requesters. Define DATA_ARB_RR_EN for
// round-robin with a last-granted pointer; otherwise port 0 has fixed priority.
module data_arb_pick
  import data_arb_pkg::*;
(
`ifdef DATA_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic grant,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic any,
  output logic winner
);

`ifdef DATA_ARB_RR_EN
  logic last;

  // Reset value names port 1 as last granted so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT_DBG;
    end else if (grant) begin
      last <= winner;
    end
  end

  always_comb begin
    any    = valid0 | valid1;
    winner = PORT_CPU;
    if (valid0 && valid1) begin
      winner = ~last;
    end else if (valid1) begin
      winner = PORT_DBG;
    end
  end
`else
  always_comb begin
    any    = valid0 | valid1;
    winner = PORT_CPU;
    if (!valid0 && valid1) begin
      winner = PORT_DBG;
    end
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-ported data_mem: latches the winner,
// strobes data_mem for one cycle, waits out the stall and returns a one-cycle ack.
// Optional round-robin arbitration via DATA_ARB_RR_EN (see data_arb_pick).
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_sign_mask,
  output logic        req0_ack,
  output logic [31:0] req0_rdata,
  output logic        req0_err,

  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_sign_mask,
  output logic        req1_ack,
  output logic [31:0] req1_rdata,
  output logic        req1_err,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_t       state;
  arb_state_t       next_state;
  arb_req_t         req0;
  arb_req_t         req1;
  arb_req_t         lat;
  logic             owner;
  logic             seen_stall;
  logic [CNT_W-1:0] wd_cnt;
  logic             any_valid;
  logic             winner;
  logic             grant;
  logic             done;
  logic             expire;

  assign req0 = {req0_write, req0_addr, req0_wdata, req0_sign_mask};
  assign req1 = {req1_write, req1_addr, req1_wdata, req1_sign_mask};

  data_arb_pick u_pick (
`ifdef DATA_ARB_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .grant  (grant),
`endif
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .any    (any_valid),
    .winner (winner)
  );

  // data_mem samples these combinationally, so they come straight from the latch.
  assign mem_addr       = lat.addr;
  assign mem_write_data = lat.wdata;
  assign mem_sign_mask  = lat.sign_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    grant        = 1'b0;
    done         = 1'b0;
    expire       = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        mem_memread  = ~lat.write;
        mem_memwrite = lat.write;
        next_state   = WAIT;
      end
      WAIT: begin
        // Completion wins over a timeout reached in the same cycle.
        if (seen_stall && !mem_clk_stall) begin
          done       = 1'b1;
          next_state = RESP;
        end else if (wd_cnt == CNT_MAX) begin
          expire     = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant latch and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat        <= '0;
      owner      <= PORT_CPU;
      seen_stall <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      if (grant) begin
        owner <= winner;
        lat   <= (winner == PORT_DBG) ? req1 : req0;
      end
      if (state == ISSUE) begin
        seen_stall <= 1'b0;
        wd_cnt     <= '0;
      end else if (state == WAIT) begin
        if (mem_clk_stall) begin
          seen_stall <= 1'b1;
        end
        if (wd_cnt != CNT_MAX) begin
          wd_cnt <= wd_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Response registers: ack is high only in RESP, rdata/err belong to the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_ack   <= 1'b0;
      req0_err   <= 1'b0;
      req0_rdata <= '0;
      req1_ack   <= 1'b0;
      req1_err   <= 1'b0;
      req1_rdata <= '0;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      if (done || expire) begin
        if (owner == PORT_CPU) begin
          req0_ack <= 1'b1;
          req0_err <= expire;
          if (expire) begin
            req0_rdata <= '0;
          end else if (!lat.write) begin
            req0_rdata <= mem_read_data;
          end
        end else begin
          req1_ack <= 1'b1;
          req1_err <= expire;
          if (expire) begin
            req1_rdata <= '0;
          end else if (!lat.write) begin
            req1_rdata <= mem_read_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: vector table of single transactions plus
// sequences for timeout, async reset, address hold and arbitration order.
module tb_data_mem_arbiter;
  import data_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic [3:0]  req0_sign_mask = '0;
  logic        req0_ack, req0_err;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [3:0]  req1_sign_mask = '0;
  logic        req1_ack, req1_err;
  logic [31:0] req1_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite, mem_clk_stall;

  int n_checks = 0;
  int n_fail = 0;

  data_mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_sign_mask(req0_sign_mask),
    .req0_ack(req0_ack), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_sign_mask(req1_sign_mask),
    .req1_ack(req1_ack), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  // Memory model: stalls for the cycle after each strobe (or forever when hang is set)
  logic [31:0] mem [0:1023];
  logic        stall_r;
  bit          hang = 1'b0;

  assign mem_clk_stall = stall_r;
  assign mem_read_data = mem[mem_addr[11:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= 1'b0;
    end else begin
      stall_r <= hang | mem_memread | mem_memwrite;
      if (mem_memwrite) begin
        if (mem_sign_mask[2]) begin
          mem[mem_addr[11:2]] <= mem_write_data;
        end else if (mem_sign_mask[1]) begin
          if (mem_addr[1]) mem[mem_addr[11:2]][31:16] <= mem_write_data[15:0];
          else             mem[mem_addr[11:2]][15:0]  <= mem_write_data[15:0];
        end else begin
          case (mem_addr[1:0])
            2'd0: mem[mem_addr[11:2]][7:0]   <= mem_write_data[7:0];
            2'd1: mem[mem_addr[11:2]][15:8]  <= mem_write_data[7:0];
            2'd2: mem[mem_addr[11:2]][23:16] <= mem_write_data[7:0];
            default: mem[mem_addr[11:2]][31:24] <= mem_write_data[7:0];
          endcase
        end
      end
    end
  end

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          lat;
    int          strobe_cyc;
    int          strobe_cnt;
    logic        strobe_wr;
    logic [31:0] rdata;
    logic        err;
    logic        addr_stable;
    logic        other_ack;
  } res_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cycle 0 is the IDLE cycle in which valid is first sampled.
  task automatic run_txn(input vec_t v, input int mut_cyc, input logic [31:0] mut_addr,
                         output res_t r);
    logic me, other;
    r = '{lat: -1, strobe_cyc: -1, strobe_cnt: 0, strobe_wr: 1'b0, rdata: '0,
          err: 1'b0, addr_stable: 1'b1, other_ack: 1'b0};
    if (v.port) begin
      req1_write = v.write; req1_addr = v.addr; req1_wdata = v.wdata;
      req1_sign_mask = v.mask; req1_valid = 1'b1;
    end else begin
      req0_write = v.write; req0_addr = v.addr; req0_wdata = v.wdata;
      req0_sign_mask = v.mask; req0_valid = 1'b1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == mut_cyc) begin
        if (v.port) req1_addr = mut_addr;
        else        req0_addr = mut_addr;
      end
      if (mem_memread || mem_memwrite) begin
        r.strobe_cnt++;
        if (r.strobe_cyc < 0) r.strobe_cyc = n;
        r.strobe_wr = mem_memwrite;
      end
      if (mem_addr !== v.addr) r.addr_stable = 1'b0;
      me    = v.port ? req1_ack : req0_ack;
      other = v.port ? req0_ack : req1_ack;
      if (other) r.other_ack = 1'b1;
      if (me) begin
        r.lat   = n;
        r.rdata = v.port ? req1_rdata : req0_rdata;
        r.err   = v.port ? req1_err : req0_err;
        break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 32'({req0_ack, req0_err, req1_ack, req1_err,
                              mem_memread, mem_memwrite, mem_sign_mask}), 32'd0);
    check({tag, "_rdata0"}, req0_rdata, 32'd0);
    check({tag, "_rdata1"}, req1_rdata, 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'd0);
    check({tag, "_mwdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    res_t r;
    int   order [5];
    int   ack_cyc [5];
    int   n_rec;
    int   n_ack;
    logic both;

    vecs[0]  = '{1'b1, 1'b1, 32'h10,   32'hDEADBEEF, SM_WORD, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h20,   32'h11223344, SM_WORD, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h10,   32'h0,        SM_WORD, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b1, 32'h21,   32'h000000A5, SM_BYTE, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h20,   32'h0,        SM_WORD, 32'h1122A544};
    vecs[5]  = '{1'b0, 1'b1, 32'h14,   32'h12345678, SM_WORD, 32'h1122A544};
    vecs[6]  = '{1'b1, 1'b0, 32'h14,   32'h0,        SM_WORD, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b1, 32'h16,   32'h0000BEEF, SM_HALF, 32'h1122A544};
    vecs[8]  = '{1'b1, 1'b0, 32'h14,   32'h0,        SM_WORD, 32'hBEEF5678};
    vecs[9]  = '{1'b0, 1'b1, 32'h2000, 32'h00000005, SM_WORD, 32'h1122A544};
    vecs[10] = '{1'b1, 1'b0, 32'h2000, 32'h0,        SM_WORD, 32'h00000005};

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("reset_released");

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i], 0, 32'h0, r);
      check($sformatf("v%0d_latency", i), r.lat, 32'd4);
      check($sformatf("v%0d_strobe_cycle", i), r.strobe_cyc, 32'd1);
      check($sformatf("v%0d_strobe_count", i), r.strobe_cnt, 32'd1);
      check($sformatf("v%0d_strobe_write", i), 32'(r.strobe_wr), 32'(vecs[i].write));
      check($sformatf("v%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(r.err), 32'd0);
      check($sformatf("v%0d_addr_stable", i), 32'(r.addr_stable), 32'd1);
      check($sformatf("v%0d_other_ack", i), 32'(r.other_ack), 32'd0);
      @(posedge clk); #1;
    end

    // Watchdog: memory never releases the stall
    hang = 1'b1;
    run_txn(vecs[2], 0, 32'h0, r);
    hang = 1'b0;
    check("timeout_latency", r.lat, 32'd18);
    check("timeout_issue_to_ack", r.lat - r.strobe_cyc, 32'd17);
    check("timeout_strobe_count", r.strobe_cnt, 32'd1);
    check("timeout_err", 32'(r.err), 32'd1);
    check("timeout_rdata", r.rdata, 32'd0);
    @(posedge clk); #1;
    run_txn(vecs[2], 0, 32'h0, r);
    check("post_timeout_latency", r.lat, 32'd4);
    check("post_timeout_rdata", r.rdata, 32'hDEADBEEF);
    check("post_timeout_err", 32'(r.err), 32'd0);
    @(posedge clk); #1;

    // Requester changes its address during WAIT
    run_txn(vecs[2], 2, 32'h3C, r);
    check("addr_hold_stable", 32'(r.addr_stable), 32'd1);
    check("addr_hold_rdata", r.rdata, 32'hDEADBEEF);
    check("addr_hold_latency", r.lat, 32'd4);
    @(posedge clk); #1;

    // Asynchronous reset in WAIT
    req0_write = 1'b0; req0_addr = 32'h10; req0_sign_mask = SM_WORD; req0_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_wait_pre_addr", mem_addr, 32'h10);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    #1;
    check_outputs_zero("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (req0_ack || req1_ack) n_ack++;
    end
    check("rst_wait_no_ack", n_ack, 32'd0);
    run_txn(vecs[4], 0, 32'h0, r);
    check("rst_next_latency", r.lat, 32'd4);
    check("rst_next_rdata", r.rdata, 32'h1122A544);

    // Arbitration order with both ports continuously requesting loads
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req0_write = 1'b0; req0_addr = 32'h10; req0_sign_mask = SM_WORD;
    req1_write = 1'b0; req1_addr = 32'h14; req1_sign_mask = SM_WORD;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n_rec = 0;
    both = 1'b0;
    for (int i = 0; i < 5; i++) begin
      order[i] = -1;
      ack_cyc[i] = -1;
    end
    for (int n = 1; n <= 60 && n_rec < 5; n++) begin
      @(posedge clk); #1;
      if (req0_ack && req1_ack) both = 1'b1;
      if (req0_ack || req1_ack) begin
        order[n_rec] = req1_ack ? 1 : 0;
        ack_cyc[n_rec] = n;
        n_rec++;
        if (n_rec == 4) req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("arb_both_acks", 32'(both), 32'd0);
    check("arb_ack_spacing", ack_cyc[1] - ack_cyc[0], 32'd5);
`ifdef DATA_ARB_RR_EN
    check("arb_grant0", order[0], 32'd0);
    check("arb_grant1", order[1], 32'd1);
    check("arb_grant2", order[2], 32'd0);
    check("arb_grant3", order[3], 32'd1);
`else
    check("arb_grant0", order[0], 32'd0);
    check("arb_grant1", order[1], 32'd0);
    check("arb_grant2", order[2], 32'd0);
    check("arb_grant3", order[3], 32'd0);
`endif
    check("arb_grant4", order[4], 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbitrates access to the single-ported `data_mem` data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader). It latches the winning request and drives `data_mem` with a one-cycle `memread`/`memwrite` strobe. It holds address, data and mask stable while `data_mem` stalls, returns the read word, and flags a watchdog timeout if the memory never completes. It sits between the requesters and `data_mem`, and replaces the direct CPU-to-`data_mem` connection.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles spent in WAIT before the transaction is aborted with an error.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  request pending, N ∈ {0,1}; held until `reqN_ack`.
- `reqN_write`  in  1  1 = store, 0 = load.
- `reqN_addr`  in  32  byte address.
- `reqN_wdata`  in  32  store data.
- `reqN_sign_mask`  in  4  `data_mem` size/sign code: bit2 = word, bit1 = half, bit3 = sign-extend.
- `reqN_ack`  out  1  one-cycle completion pulse.
- `reqN_rdata`  out  32  load result; valid while `reqN_ack` is high.
- `reqN_err`  out  1  timeout flag; valid while `reqN_ack` is high.
- `mem_addr`, `mem_write_data`  out  32  to `data_mem`.
- `mem_sign_mask`  out  4  to `data_mem`.
- `mem_memread`, `mem_memwrite`  out  1  to `data_mem`.
- `mem_read_data`  in  32  from `data_mem`.
- `mem_clk_stall`  in  1  from `data_mem`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `reqN_valid` is high: pick a winner, latch its write/addr/wdata/sign_mask into internal registers, record the owner, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly one cycle)
  - Assert `mem_memread` or `mem_memwrite` according to the latched write bit.
  - Clear `seen_stall`, clear the timeout counter, go to WAIT.
- **WAIT**
  - Both strobes are low.
  - `seen_stall` is set when `mem_clk_stall`=1.
  - Completion: `seen_stall` && `mem_clk_stall`=0. On completion, register `mem_read_data` into the owner's `rdata` (only for loads; stores leave `rdata` unchanged), set `ack`, clear `err`, go to RESP.
  - Timeout: counter reaches `TIMEOUT` before completion. Set `ack`=1, `err`=1, `rdata`=0, go to RESP.
- **RESP**
  - The owner's `ack` is high for this one cycle; the other port's `ack` stays 0.
  - Go to IDLE.
- Memory drive
  - `mem_addr`, `mem_write_data` and `mem_sign_mask` are driven from the latched registers in every state.
  - These values stay stable from ISSUE until the next grant. `data_mem` samples them combinationally, so this stability is mandatory.
- Requester contract
  - Hold `valid` and all fields until `ack`.
  - `valid` must be low, or carry a new request, in the cycle after `ack`.
  - If a requester drops `valid` early, the latched transaction still completes and still acks.
- Boundary conditions
  - Both ports valid in IDLE: the policy under Configuration decides.
  - A request arriving in the RESP cycle is not sampled until IDLE.
  - Address 0x2000 (LED) is forwarded like any other address.
  - Reset mid-transaction: the FSM aborts to IDLE and no ack is issued. A store already strobed may still land in `data_mem`.

## Timing
- Reset values: all outputs 0, state IDLE, latched registers 0, round-robin pointer favours port 0.
- Nominal load or store latency: `valid` sampled in IDLE at cycle 0; ISSUE in cycle 1; WAIT in cycles 2–3 (`mem_clk_stall` high in cycle 2, low in cycle 3); `ack` in cycle 4.
- Throughput: at most one transaction per 5 cycles.
- Timeout: `ack` with `err`=1 appears `TIMEOUT`+2 cycles after ISSUE.
- Counter width: `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.

## Configuration
- `DATA_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the last port granted.
  - On a tie, the other port wins.
  - The pointer updates only on a grant.
- `DATA_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. No pointer register exists.

## Structure
- Package `data_arb_pkg` holds:
  - state encodings IDLE/ISSUE/WAIT/RESP;
  - port-ID constants `PORT_CPU`=0 and `PORT_DBG`=1;
  - sign_mask constants: `SM_WORD`=4'b0100, `SM_HALF`=4'b0010, `SM_BYTE`=4'b0000, `SM_SIGNED`=4'b1000.
- Sub-module `data_arb_pick`: combinational winner selection plus the optional pointer register, with all `DATA_ARB_RR_EN` logic confined there.
- The top level holds the FSM, latches, watchdog and response registers.

## Test plan
- Port 0 loads word at addr 0x10, memory preloaded with 0xDEADBEEF: `mem_memread` high in cycle 1 only; `req0_ack` in cycle 4 with `rdata`=0xDEADBEEF, `err`=0.
- Port 1 stores byte 0xA5 to 0x21 (sign_mask 0000), then port 0 loads word 0x20: the word reads back with byte 1 = 0xA5 and other bytes unchanged.
- Both ports valid with continuous loads: with `DATA_ARB_RR_EN`, grants alternate 0,1,0,1; without it, port 0 starves port 1 until it drops `valid`.
- Memory model holds `mem_clk_stall` high forever with `TIMEOUT`=15: `ack` and `err`=1, `rdata`=0, 17 cycles after ISSUE; the FSM then returns to IDLE.
- `rst_n` pulsed low during WAIT: all outputs go to 0 immediately (asynchronously); no `ack` is produced; the next request completes normally.
- `req0_addr` changed while in WAIT (protocol violation): `mem_addr` stays at the latched value.
